// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

  // LC-3b machine word, used for both addresses and data.
  typedef logic [15:0] lc3b_word;

  // Per-byte write strobes for a 16-bit word (STB uses one lane).
  typedef logic [1:0] lc3b_mem_byte_en;

  // Grant FSM states: free, serving fetch, serving data port.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_t;

  // Encoding of the last_grant register.
  localparam logic LAST_I = 1'b0;
  localparam logic LAST_D = 1'b1;

  // Full-word enable used for instruction fetches.
  localparam lc3b_mem_byte_en BE_WORD = 2'b11;

endpackage

// File: rtl/mem_port_arbiter.sv
// Two-port to one-port memory arbiter: instruction fetch (read-only) and
// data port (read/write) share a single downstream memory interface.
// A grant is registered in IDLE, held until mem_resp, then the FSM returns
// to IDLE for one bubble cycle. Contention is resolved round-robin.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,

  input  logic                  req1_read,
  input  logic [ADDR_W-1:0]     req1_addr,
  output logic                  resp1,
  output logic [DATA_W-1:0]     rdata1,

  input  logic                  req2_read,
  input  logic                  req2_write,
  input  logic [ADDR_W-1:0]     req2_addr,
  input  logic [DATA_W-1:0]     req2_wdata,
  input  lc3b_mem_byte_en       req2_byte_en,
  output logic                  resp2,
  output logic [DATA_W-1:0]     rdata2,

  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output lc3b_mem_byte_en       mem_byte_en,
  input  logic                  mem_resp,
  input  logic [DATA_W-1:0]     mem_rdata
);

  arb_state_t state;
  logic       last_grant;
  logic       req1;
  logic       req2;

  assign req1 = req1_read;
  assign req2 = req2_read | req2_write;

  // Grant FSM: pick a requester in IDLE, hold the grant until mem_resp.
  // last_grant starts at D so the fetch port wins the first contention.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= LAST_D;
    end else begin
      case (state)
        IDLE: begin
          if (req1 && (!req2 || last_grant == LAST_D)) state <= GRANT_I;
          else if (req2)                               state <= GRANT_D;
        end
        GRANT_I: begin
          if (mem_resp) begin
            state      <= IDLE;
            last_grant <= LAST_I;
          end
        end
        GRANT_D: begin
          if (mem_resp) begin
            state      <= IDLE;
            last_grant <= LAST_D;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Downstream strobes and upstream responses follow the current grant and
  // the live requester inputs; everything is zero for the idle side.
  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_byte_en = '0;
    resp1       = 1'b0;
    rdata1      = '0;
    resp2       = 1'b0;
    rdata2      = '0;
    case (state)
      GRANT_I: begin
        mem_read    = 1'b1;
        mem_addr    = req1_addr;
        mem_byte_en = BE_WORD;
        if (mem_resp) begin
          resp1  = 1'b1;
          rdata1 = mem_rdata;
        end
      end
      GRANT_D: begin
        // Both strobes pass through untouched; a read+write pair is a
        // requester bug and is not filtered here.
        mem_read    = req2_read;
        mem_write   = req2_write;
        mem_addr    = req2_addr;
        mem_wdata   = req2_wdata;
        mem_byte_en = req2_byte_en;
        if (mem_resp) begin
          resp2  = 1'b1;
          rdata2 = mem_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues the expected
// downstream transactions in expected grant order; a memory model answers
// them and a single monitor compares every response and strobe.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req1_read = 1'b0;
  logic [15:0] req1_addr = '0;
  logic        resp1;
  logic [15:0] rdata1;
  logic        req2_read = 1'b0;
  logic        req2_write = 1'b0;
  logic [15:0] req2_addr = '0;
  logic [15:0] req2_wdata = '0;
  logic [1:0]  req2_byte_en = '0;
  logic        resp2;
  logic [15:0] rdata2;
  logic        mem_read, mem_write;
  logic [15:0] mem_addr, mem_wdata;
  logic [1:0]  mem_byte_en;
  logic        mem_resp = 1'b0;
  logic [15:0] mem_rdata = '0;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .req1_read(req1_read), .req1_addr(req1_addr), .resp1(resp1), .rdata1(rdata1),
    .req2_read(req2_read), .req2_write(req2_write), .req2_addr(req2_addr),
    .req2_wdata(req2_wdata), .req2_byte_en(req2_byte_en),
    .resp2(resp2), .rdata2(rdata2),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_byte_en(mem_byte_en),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          port2;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] rdata;
    int          wt;
  } txn_t;

  txn_t exp_q[$];

  int errors = 0;
  int checks = 0;
  bit exp_idle = 1'b0;
  bit inj = 1'b0;
  bit inj_active = 1'b0;
  bit done = 1'b0;

  function automatic void expect_txn(bit p2, logic rd, logic wr, logic [15:0] a,
                                     logic [15:0] wd, logic [1:0] be,
                                     logic [15:0] rdat, int wt);
    txn_t t;
    t.port2 = p2; t.rd = rd; t.wr = wr; t.addr = a; t.wdata = wd;
    t.be = be; t.rdata = rdat; t.wt = wt;
    exp_q.push_back(t);
  endfunction

  // Memory model: answers the front expected transaction after its wait
  // count, or raises an unsolicited pulse when inj is set.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk); #2;
      if (!reset_n) begin
        mem_resp = 1'b0; inj_active = 1'b0; cnt = 0;
      end else if (mem_resp) begin
        mem_resp = 1'b0; inj_active = 1'b0; mem_rdata = '0; cnt = 0;
      end else if (inj) begin
        mem_resp = 1'b1; inj_active = 1'b1; mem_rdata = 16'hBEEF;
      end else if ((mem_read || mem_write) && exp_q.size() > 0) begin
        if (cnt >= exp_q[0].wt) begin
          mem_resp  = 1'b1;
          mem_rdata = exp_q[0].rdata;
        end else cnt++;
      end else if (!(mem_read || mem_write)) cnt = 0;
    end
  end

  task automatic chk(input logic [63:0] act, input logic [63:0] req, input string name);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk)
    if (reset_n) assert (!(req2_read && req2_write));

  // Monitor: the only process that compares and counts.
  initial begin
    bit   prev_resp, chk_regrant;
    txn_t t;
    prev_resp = 1'b0; chk_regrant = 1'b0;
    forever begin
      @(negedge clk);
      if (done) break;
      if (chk_regrant) begin
        chk(64'(mem_read | mem_write), 64'd1, "regrant_after_one_bubble");
        chk_regrant = 1'b0;
      end
      if (prev_resp) begin
        chk(64'({mem_read, mem_write, resp1, resp2}), 64'd0, "idle_bubble");
        chk_regrant = req1_read | req2_read | req2_write;
      end
      prev_resp = resp1 | resp2;

      if (exp_idle) begin
        chk(64'({mem_read, mem_write, resp1, resp2, mem_byte_en}), 64'd0, "idle_ctrl");
        chk({mem_addr, mem_wdata, rdata1, rdata2}, 64'd0, "idle_data");
      end

      if ((mem_read || mem_write) && exp_q.size() > 0 && !inj_active) begin
        t = exp_q[0];
        chk(64'({mem_read, mem_write}), 64'({t.rd, t.wr}), "strobes");
        chk(64'(mem_addr), 64'(t.addr), "mem_addr");
        chk(64'(mem_byte_en), 64'(t.be), "mem_byte_en");
        if (t.wr) chk(64'(mem_wdata), 64'(t.wdata), "mem_wdata");
      end

      if (mem_resp && inj_active) begin
        chk(64'({resp1, resp2}), 64'd0, "late_mem_resp_ignored");
      end else if (mem_resp) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_mem_resp: queue empty at %0t", $time);
        end else begin
          t = exp_q.pop_front();
          chk(64'({resp1, resp2}), t.port2 ? 64'd1 : 64'd2, "resp_port");
          chk(64'(t.port2 ? rdata2 : rdata1), 64'(t.rdata), "rdata");
          chk(64'(t.port2 ? rdata1 : rdata2), 64'd0, "rdata_other");
        end
      end else if (resp1 || resp2) begin
        chk(64'({resp1, resp2}), 64'd0, "spurious_resp");
      end
    end
    chk(64'(exp_q.size()), 64'd0, "all_txns_served");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  task automatic do1(input logic [15:0] a, input bit keep);
    bit got;
    got = 1'b0;
    req1_read = 1'b1; req1_addr = a;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (resp1) begin got = 1'b1; break; end
    end
    if (!got) begin
      $display("FAIL resp1_timeout: no resp1 for addr %0h", a);
      $fatal(1, "stopping: fetch port stalled");
    end
    @(posedge clk); #1;
    if (!keep) req1_read = 1'b0;
  endtask

  task automatic do2(input logic rd, input logic wr, input logic [15:0] a,
                     input logic [15:0] wd, input logic [1:0] be, input bit keep);
    bit got;
    got = 1'b0;
    req2_read = rd; req2_write = wr; req2_addr = a; req2_wdata = wd; req2_byte_en = be;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (resp2) begin got = 1'b1; break; end
    end
    if (!got) begin
      $display("FAIL resp2_timeout: no resp2 for addr %0h", a);
      $fatal(1, "stopping: data port stalled");
    end
    @(posedge clk); #1;
    if (!keep) begin req2_read = 1'b0; req2_write = 1'b0; end
  endtask

  task automatic do_reset();
    @(posedge clk); #1; reset_n = 1'b0;
    @(posedge clk); #1; reset_n = 1'b1; exp_idle = 1'b1;
    @(posedge clk); #1; exp_idle = 1'b0;
  endtask

  // Directed stimulus.
  initial begin
    bit seen;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1; exp_idle = 1'b1;
    @(posedge clk); #1 exp_idle = 1'b0;

    // Lone fetch, two memory wait cycles.
    expect_txn(0, 1, 0, 16'h0040, 16'h0000, 2'b11, 16'h1234, 2);
    do1(16'h0040, 0);

    // Lone byte store.
    expect_txn(1, 0, 1, 16'h2001, 16'h00AB, 2'b10, 16'h5A5A, 1);
    do2(0, 1, 16'h2001, 16'h00AB, 2'b10, 0);

    // Simultaneous requests right after reset: fetch first.
    do_reset();
    expect_txn(0, 1, 0, 16'h0100, 16'h0000, 2'b11, 16'hA001, 0);
    expect_txn(1, 1, 0, 16'h3000, 16'h0000, 2'b11, 16'hD001, 0);
    fork
      do1(16'h0100, 0);
      do2(1, 0, 16'h3000, 16'h0000, 2'b11, 0);
    join

    // Both held for six transactions: strict I,D alternation.
    expect_txn(0, 1, 0, 16'h0200, 16'h0000, 2'b11, 16'hA100, 1);
    expect_txn(1, 0, 1, 16'h4000, 16'hCAFE, 2'b11, 16'h0000, 0);
    expect_txn(0, 1, 0, 16'h0202, 16'h0000, 2'b11, 16'hA102, 3);
    expect_txn(1, 1, 0, 16'h4002, 16'h0000, 2'b11, 16'hD102, 2);
    expect_txn(0, 1, 0, 16'h0204, 16'h0000, 2'b11, 16'hA104, 0);
    expect_txn(1, 0, 1, 16'h4004, 16'h3C00, 2'b01, 16'h0000, 1);
    fork
      begin
        do1(16'h0200, 1); do1(16'h0202, 1); do1(16'h0204, 0);
      end
      begin
        do2(0, 1, 16'h4000, 16'hCAFE, 2'b11, 1);
        do2(1, 0, 16'h4002, 16'h0000, 2'b11, 1);
        do2(0, 1, 16'h4004, 16'h3C00, 2'b01, 0);
      end
    join

    // Back-to-back fetches with the address replaced after resp1.
    expect_txn(0, 1, 0, 16'h0040, 16'h0000, 2'b11, 16'h1111, 0);
    expect_txn(0, 1, 0, 16'h0042, 16'h0000, 2'b11, 16'h2222, 1);
    do1(16'h0040, 1);
    do1(16'h0042, 0);

    // Reset in the middle of a data grant; memory never answers it.
    req2_write = 1'b1; req2_addr = 16'h5000; req2_wdata = 16'h7777; req2_byte_en = 2'b11;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_write) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      $display("FAIL grant_d_timeout: mem_write never rose");
      $fatal(1, "stopping: data grant missing");
    end
    @(posedge clk); #1 reset_n = 1'b0; req2_write = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1; exp_idle = 1'b1;
    @(posedge clk); inj = 1'b1;
    @(posedge clk); inj = 1'b0;
    @(posedge clk); #1 exp_idle = 1'b0;

    repeat (3) @(posedge clk);
    done = 1'b1;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one physical memory interface between the pipeline's instruction-fetch port (port 1, read-only) and its data-memory port (port 2, read/write).
- Sits between cpu_datapath and the single memory model.
- Registered grant FSM with a one-cycle arbitration stage and round-robin fairness on contention.
- Returns a one-cycle response pulse and read data to the granted requester only.

Parameters:
- ADDR_W, 16, address width (lc3b_word)
- DATA_W, 16, data width (lc3b_word)

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset; one clock; reset is sampled on the rising edge of clk
- req1_read  in  1  fetch-port read request, held until resp1
- req1_addr  in  ADDR_W  fetch address
- resp1  out  1  one-cycle pulse: fetch access complete
- rdata1  out  DATA_W  fetch read data, valid when resp1=1
- req2_read  in  1  data-port read request, held until resp2
- req2_write  in  1  data-port write request, held until resp2
- req2_addr  in  ADDR_W  data address
- req2_wdata  in  DATA_W  write data
- req2_byte_en  in  2  byte enables for writes (STB)
- resp2  out  1  one-cycle pulse: data access complete
- rdata2  out  DATA_W  data read data, valid when resp2=1
- mem_read  out  1  downstream read strobe
- mem_write  out  1  downstream write strobe
- mem_addr  out  ADDR_W  downstream address
- mem_wdata  out  DATA_W  downstream write data
- mem_byte_en  out  2  downstream byte enables
- mem_resp  in  1  downstream completion pulse
- mem_rdata  in  DATA_W  downstream read data

Behaviour:
- States: IDLE, GRANT_I, GRANT_D. Plus a 1-bit last_grant register (0=I, 1=D).
- Reset (reset_n=0 at a clk edge):
  - state goes to IDLE and last_grant to 1, so I wins the first contention.
  - All outputs go to 0: mem_read, mem_write, resp1, resp2, mem_addr, mem_wdata, mem_byte_en, rdata1, rdata2.
  - Reset mid-access abandons the transaction. Any mem_resp arriving afterwards while in IDLE is ignored.
- IDLE, evaluated each edge:
  - req1 = req1_read; req2 = req2_read | req2_write.
  - Only req1 -> GRANT_I. Only req2 -> GRANT_D.
  - Both -> the port opposite last_grant. Neither -> stay.
  - Downstream strobes are 0 in IDLE.
- GRANT_I:
  - mem_read=1, mem_write=0, mem_addr=req1_addr, mem_byte_en=2'b11.
  - Outputs are combinational from state and live requester inputs.
  - On mem_resp=1 in the same cycle: resp1=1 and rdata1=mem_rdata. Next state IDLE; last_grant<=0.
- GRANT_D:
  - mem_read=req2_read, mem_write=req2_write, mem_addr=req2_addr, mem_wdata=req2_wdata, mem_byte_en=req2_byte_en.
  - On mem_resp: resp2=1 and rdata2=mem_rdata. Next state IDLE; last_grant<=1.
- Non-granted side: resp is held 0; rdata is 0.
- Latency: request seen in IDLE at edge N -> strobes asserted in cycle N+1 -> resp in the same cycle as mem_resp. Minimum request-to-resp is 2 cycles with a zero-wait memory. One IDLE bubble separates consecutive grants.
- Requester rules:
  - Address, data and strobes stay stable from request until the resp cycle inclusive.
  - A requester drops or replaces its request on the edge following resp.
  - A request still held in the IDLE cycle after resp is treated as a new request.
- req2_read and req2_write both asserted is illegal: the bench asserts on it. The RTL passes both strobes through unchanged.
- A request withdrawn before resp is illegal. The FSM stays in the grant state until mem_resp.
- mem_resp in IDLE is ignored.
- No timeout. A stuck memory holds the grant indefinitely.

Decomposition:
- lc3b_types already supplies lc3b_word.
- Add to the package:
  - arb_state_t enum {IDLE, GRANT_I, GRANT_D}.
  - lc3b_mem_byte_en typedef (logic [1:0]).
- Single module. The round-robin pick (2-input, last_grant) is small enough to inline. No sub-module.

Test Plan:
- Reset then lone fetch: req1_read=1, req1_addr=16'h0040, memory returns 16'h1234 after 2 wait cycles -> mem_read=1 with mem_addr=16'h0040 from cycle 2; resp1 pulses one cycle with rdata1=16'h1234; resp2 stays 0.
- Lone store byte: req2_write=1, addr=16'h2001, wdata=16'h00AB, byte_en=2'b10 -> mem_write=1 with those exact values; resp2 pulses once; mem_read=0 throughout.
- Simultaneous requests immediately after reset -> I served first (last_grant=1 at reset). D is granted in the cycle after the IDLE bubble that follows resp1. Total 2 grants, each resp pulse exactly 1 cycle.
- Both held continuously for 6 transactions -> grants alternate I,D,I,D,I,D; no port is served twice in a row.
- reset_n=0 for one cycle while in GRANT_D with mem_resp pending -> next cycle all strobes are 0 and state is IDLE. A late mem_resp=1 in IDLE produces no resp1/resp2.
- Back-to-back fetches: req1 held with new addr 16'h0042 on the edge after resp1 -> the second grant begins after exactly one IDLE cycle with mem_addr=16'h0042.
